// File: rtl/multicycle_main_fsm.sv
// rtl/multicycle_main_fsm.sv - main control FSM of the multi-cycle RV32I core
module multicycle_main_fsm #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [6:0]         Op,
    input  logic               Zero,
    input  logic               MemReady,
    output logic               PCWrite,
    output logic               AdrSrc,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               RegWrite,
    output logic [1:0]         ResultSrc,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ALUOp,
    output logic               IllegalInstr,
    output logic [STATE_W-1:0] StateDbg
);

    typedef enum logic [STATE_W-1:0] {
        S_RST      = 0,
        S_FETCH    = 1,
        S_DECODE   = 2,
        S_MEMADR   = 3,
        S_MEMREAD  = 4,
        S_MEMWB    = 5,
        S_MEMWRITE = 6,
        S_EXECUTER = 7,
        S_EXECUTEI = 8,
        S_ALUWB    = 9,
        S_BEQ      = 10,
        S_JAL      = 11,
        S_ILLEGAL  = 12
    } state_e;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    state_e state_q;
    state_e state_d;
    logic   pc_update;
    logic   branch;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RST:      state_d = S_FETCH;
            S_FETCH:    state_d = MemReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (Op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECUTER;
                    OP_ITYPE:          state_d = S_EXECUTEI;
                    OP_BEQ:            state_d = S_BEQ;
                    OP_JAL:            state_d = S_JAL;
                    default:           state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR:   state_d = (Op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = MemReady ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = MemReady ? S_FETCH : S_MEMWRITE;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BEQ:      state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_ILLEGAL:  state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    // Outputs decode straight from state_q so an asynchronous reset drops
    // every strobe (notably a held MemWrite) without waiting for a clock edge.
    always_comb begin
        pc_update    = 1'b0;
        branch       = 1'b0;
        AdrSrc       = 1'b0;
        MemWrite     = 1'b0;
        IRWrite      = 1'b0;
        RegWrite     = 1'b0;
        ResultSrc    = 2'b00;
        ALUSrcA      = 2'b00;
        ALUSrcB      = 2'b00;
        ALUOp        = 2'b00;
        IllegalInstr = 1'b0;
        case (state_q)
            S_FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = MemReady;
                pc_update = MemReady;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD:  AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECUTER: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
            end
            S_EXECUTEI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
            end
            S_ALUWB:    RegWrite = 1'b1;
            S_BEQ: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b01;
                branch  = 1'b1;
            end
            S_JAL: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                pc_update = 1'b1;
            end
            S_ILLEGAL:  IllegalInstr = 1'b1;
            default: ;
        endcase
    end

    assign PCWrite  = pc_update | (branch & Zero);
    assign StateDbg = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RST;
        end else begin
            state_q <= state_d;
        end
    end

endmodule
